imem_loader: RTL

- Writer side of the instruction-memory interface: loads a program into a writable instruction RAM, which the fetch stage reads by word index address[9:2].
- Accepts a byte stream, for example from a UART receiver, assembles big-endian 32-bit words, issues one-cycle RAM write strobes at consecutive word-aligned addresses, and holds the CPU while loading.
- Sits between the byte source and the instruction RAM write port.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The instruction RAM uses IMEM_ADDR_WIDTH for its word-index width.
package imem_loader_pkg;

  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 32;
  localparam int IMEM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Shifts bytes MSB-first into a 32-bit word and pulses o_word_ready for one
// cycle, the cycle after the fourth byte; o_word is the full word during it.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  logic [WORD_W-1:0] r_shift;
  logic [1:0]        r_idx;
  logic              r_word_ready;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_shift      <= '0;
      r_idx        <= 2'd0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= i_shift && (r_idx == 2'd3);
      if (i_shift) begin
        r_shift <= {r_shift[WORD_W-BYTE_W-1:0], i_byte};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  assign o_word       = r_shift;
  assign o_word_ready = r_word_ready;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction RAM while
// holding the CPU. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output state_t                dbg_state
);

  localparam int CW = ADDR_WIDTH + 1;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_len;
  logic [CW-1:0]   r_word_count;
  logic [15:0]     w_len_n;
  logic            w_accept;
  logic            w_start;
  logic            w_shift;
  logic            w_word_ready;
  logic            w_last_write;
  logic [WORD_W-1:0] w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
`endif

  assign byte_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA)   || (r_state == S_CHK);
  assign w_accept   = byte_valid && byte_ready;
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERR));
  assign w_len_n    = {r_len[15:8], byte_data};
  // The last write cycle can also carry the next byte (checksum); it is not data.
  assign w_last_write = w_word_ready && (16'(r_word_count) == r_len - 16'd1);
  assign w_shift      = w_accept && (r_state == S_DATA) && !w_last_write;

  imem_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start),
    .i_shift      (w_shift),
    .i_byte       (byte_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_DONE;
`endif
          end else if (w_len_n > 16'(MAX_WORDS)) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_last_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_accept) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
          else          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_accept) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= 16'd0;
      r_word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_start) r_word_count <= '0;
      else if (w_word_ready && (r_state == S_DATA)) r_word_count <= r_word_count + CW'(1);
      if (w_accept && (r_state == S_LEN_HI)) r_len[15:8] <= byte_data;
      if (w_accept && (r_state == S_LEN_LO)) r_len[7:0]  <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_start)      r_csum <= '0;
      else if (w_shift) r_csum <= r_csum ^ byte_data;
`endif
    end
  end

  assign mem_we     = w_word_ready && (r_state == S_DATA);
  assign mem_addr   = 32'({r_word_count, 2'b00});
  assign mem_wdata  = w_word;
  assign cpu_hold   = byte_ready || (r_state == S_ERR);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign word_count = r_word_count;
  assign dbg_state  = r_state;

endmodule
